// File: rtl/bin_to_bcd_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD converter.
package bin_to_bcd_pkg;

    localparam int BIN_W       = 14;
    localparam int DIGITS      = 4;
    localparam int ACC_DIGITS  = 5;
    localparam int MAX_DISPLAY = 9999;

    // Counter value on the cycle that performs the final (14th) shift.
    localparam logic [3:0] ITER_LAST = 4'd13;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit corrector: adds 3 to a BCD digit of 5 or more, before the shift doubles it.
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative 14-bit binary to 4-digit BCD converter; one shift per cycle, result in 14 cycles.
// bcd_out/ovf hold between conversions; start is ignored while busy.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  ready,
    output logic [DIGITS*4-1:0]   bcd_out,
    output logic                  ovf,
    output logic                  out_valid
);

    import bin_to_bcd_pkg::*;

    localparam int ACC_W = ACC_DIGITS * 4;
    localparam int OUT_W = DIGITS * 4;

    state_t             state;
    state_t             state_nx;
    logic [BIN_W-1:0]   bin_sr;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_adj;
    logic [ACC_W-1:0]   acc_nx;
    logic [BIN_W-1:0]   bin_nx;
    logic [3:0]         iter;
    logic               last_shift;

    // Digits are corrected independently; no carry crosses a digit boundary.
    for (genvar g = 0; g < ACC_DIGITS; g++) begin : g_adj
        bcd_add3 u_add3 (
            .d (acc[g*4 +: 4]),
            .q (acc_adj[g*4 +: 4])
        );
    end

    assign acc_nx     = {acc_adj[ACC_W-2:0], bin_sr[BIN_W-1]};
    assign bin_nx     = {bin_sr[BIN_W-2:0], 1'b0};
    assign last_shift = (state == SHIFT) && (iter == ITER_LAST);
    assign ready      = (state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (iter == ITER_LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_sr    <= '0;
            acc       <= '0;
            iter      <= '0;
            bcd_out   <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    bin_sr <= bin_in;
                    acc    <= '0;
                    iter   <= '0;
                end
            end else begin
                bin_sr <= bin_nx;
                acc    <= acc_nx;
                iter   <= iter + 4'd1;
            end
            // The top accumulator digit only feeds the overflow flag.
            if (last_shift) begin
                bcd_out   <= acc_nx[OUT_W-1:0];
                ovf       <= |acc_nx[ACC_W-1:OUT_W];
                out_valid <= 1'b1;
            end
        end
    end

endmodule
